// File: rtl/tinyml_isa_pkg.sv
// Shared ISA definitions for the TinyML accelerator sequencer: opcodes,
// instruction field positions, execution unit indices and error codes.
package tinyml_isa_pkg;

  localparam int INSTR_W      = 64;
  localparam int FIELD_LEN_W  = 20;
  localparam int FIELD_ADDR_W = 24;
  localparam int NUM_UNITS    = 4;

  localparam int OPCODE_MSB = 63;
  localparam int OPCODE_LSB = 59;
  localparam int DEST_MSB   = 58;
  localparam int DEST_LSB   = 54;
  localparam int SRC1_MSB   = 53;
  localparam int SRC1_LSB   = 49;
  localparam int SRC2_MSB   = 48;
  localparam int SRC2_LSB   = 44;
  localparam int LEN_MSB    = 43;
  localparam int LEN_LSB    = 24;
  localparam int ADDR_MSB   = 23;
  localparam int ADDR_LSB   = 0;

  localparam int UNIT_LOAD  = 0;
  localparam int UNIT_STORE = 1;
  localparam int UNIT_GEMV  = 2;
  localparam int UNIT_RELU  = 3;

  typedef enum logic [4:0] {
    OP_NOP    = 5'd0,
    OP_LOAD_V = 5'd1,
    OP_LOAD_M = 5'd2,
    OP_STORE  = 5'd3,
    OP_GEMV   = 5'd4,
    OP_RELU   = 5'd5,
    OP_HALT   = 5'd31
  } opcode_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_ILLEGAL = 2'd1,
    ERR_TIMEOUT = 2'd2
  } err_code_e;

endpackage

// File: rtl/instr_field_decode.sv
// Purely combinational instruction decoder: splits a 64-bit instruction into
// its fields and classifies the opcode (target unit, matrix load, halt, nop).
module instr_field_decode
  import tinyml_isa_pkg::*;
(
  input  logic [INSTR_W-1:0]      instr,
  output logic [4:0]              dest,
  output logic [4:0]              src1,
  output logic [4:0]              src2,
  output logic [FIELD_LEN_W-1:0]  len,
  output logic [FIELD_ADDR_W-1:0] addr,
  output logic [NUM_UNITS-1:0]    unit_onehot,
  output logic                    is_mat,
  output logic                    illegal,
  output logic                    is_halt,
  output logic                    is_nop
);

  logic [4:0] opcode;

  assign opcode = instr[OPCODE_MSB:OPCODE_LSB];
  assign dest   = instr[DEST_MSB:DEST_LSB];
  assign src1   = instr[SRC1_MSB:SRC1_LSB];
  assign src2   = instr[SRC2_MSB:SRC2_LSB];
  assign len    = instr[LEN_MSB:LEN_LSB];
  assign addr   = instr[ADDR_MSB:ADDR_LSB];

  // Both load flavours share the load unit; only LOAD_M flags a matrix target.
  always_comb begin
    unit_onehot = '0;
    is_mat      = 1'b0;
    illegal     = 1'b0;
    is_halt     = 1'b0;
    is_nop      = 1'b0;
    case (opcode)
      OP_NOP:    is_nop = 1'b1;
      OP_LOAD_V: unit_onehot[UNIT_LOAD] = 1'b1;
      OP_LOAD_M: begin
        unit_onehot[UNIT_LOAD] = 1'b1;
        is_mat                 = 1'b1;
      end
      OP_STORE:  unit_onehot[UNIT_STORE] = 1'b1;
      OP_GEMV:   unit_onehot[UNIT_GEMV]  = 1'b1;
      OP_RELU:   unit_onehot[UNIT_RELU]  = 1'b1;
      OP_HALT:   is_halt = 1'b1;
      default:   illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_dispatch_ctrl.sv
// Instruction sequencer: fetches one instruction at a time, decodes it and
// dispatches it to one of four execution units, with halt/error/timeout handling.
module instr_dispatch_ctrl
  import tinyml_isa_pkg::*;
#(
  parameter int INSTR_WIDTH    = 64,
  parameter int ADDR_WIDTH     = 24,
  parameter int LEN_WIDTH      = 20,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start_i,
  input  logic                   clear_i,
  output logic                   fetch_en_o,
  input  logic                   fetch_done_i,
  input  logic [INSTR_WIDTH-1:0] instr_i,
  output logic [3:0]             unit_start_o,
  input  logic [3:0]             unit_done_i,
  output logic                   load_is_mat_o,
  output logic [4:0]             dest_o,
  output logic [4:0]             src1_o,
  output logic [4:0]             src2_o,
  output logic [LEN_WIDTH-1:0]   len_o,
  output logic [ADDR_WIDTH-1:0]  addr_o,
  output logic                   busy_o,
  output logic                   halted_o,
  output logic                   err_o,
  output logic [1:0]             err_code_o,
  output logic [31:0]            instr_count_o
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_FETCH    = 3'd1;
  localparam logic [2:0] S_WAIT_F   = 3'd2;
  localparam logic [2:0] S_DECODE   = 3'd3;
  localparam logic [2:0] S_DISPATCH = 3'd4;
  localparam logic [2:0] S_EXEC     = 3'd5;
  localparam logic [2:0] S_HALTED   = 3'd6;
  localparam logic [2:0] S_ERROR    = 3'd7;

  localparam int            TW    = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

  logic [2:0]              state;
  logic [INSTR_WIDTH-1:0]  instr_q;
  logic [TW-1:0]           tcount;
  logic [31:0]             count_q;
  logic [1:0]              err_code_q;
  logic [3:0]              unit_sel_q;

  logic [4:0]              dec_dest;
  logic [4:0]              dec_src1;
  logic [4:0]              dec_src2;
  logic [FIELD_LEN_W-1:0]  dec_len;
  logic [FIELD_ADDR_W-1:0] dec_addr;
  logic [3:0]              dec_unit;
  logic                    dec_mat;
  logic                    dec_illegal;
  logic                    dec_halt;
  logic                    dec_nop;

  instr_field_decode u_decode (
    .instr       (instr_q),
    .dest        (dec_dest),
    .src1        (dec_src1),
    .src2        (dec_src2),
    .len         (dec_len),
    .addr        (dec_addr),
    .unit_onehot (dec_unit),
    .is_mat      (dec_mat),
    .illegal     (dec_illegal),
    .is_halt     (dec_halt),
    .is_nop      (dec_nop)
  );

  // Main sequencer; clear_i outranks every transition and keeps the retire count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      instr_q    <= '0;
      tcount     <= '0;
      count_q    <= '0;
      err_code_q <= ERR_NONE;
      unit_sel_q <= '0;
    end else if (clear_i) begin
      state      <= S_IDLE;
      err_code_q <= ERR_NONE;
    end else begin
      case (state)
        S_IDLE:   if (start_i) state <= S_FETCH;
        S_FETCH:  state <= S_WAIT_F;
        S_WAIT_F: begin
          if (fetch_done_i) begin
            instr_q <= instr_i;
            state   <= S_DECODE;
          end
        end
        S_DECODE: begin
          unit_sel_q <= dec_unit;
          if (dec_nop) begin
            count_q <= count_q + 32'd1;
            state   <= S_FETCH;
          end else if (dec_halt) begin
            count_q <= count_q + 32'd1;
            state   <= S_HALTED;
          end else if (dec_illegal) begin
            err_code_q <= ERR_ILLEGAL;
            state      <= S_ERROR;
          end else begin
            state <= S_DISPATCH;
          end
        end
        S_DISPATCH: begin
          tcount <= '0;
          state  <= S_EXEC;
        end
        // A done on the final allowed cycle still retires instead of timing out.
        S_EXEC: begin
          if (|(unit_done_i & unit_sel_q)) begin
            count_q <= count_q + 32'd1;
            state   <= S_FETCH;
          end else if (tcount == TLAST) begin
            err_code_q <= ERR_TIMEOUT;
            state      <= S_ERROR;
          end else begin
            tcount <= tcount + TW'(1);
          end
        end
        S_HALTED: if (start_i) state <= S_FETCH;
        default:  ;
      endcase
    end
  end

  // Decoded fields stay visible until the next instruction is decoded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_is_mat_o <= 1'b0;
      dest_o        <= '0;
      src1_o        <= '0;
      src2_o        <= '0;
      len_o         <= '0;
      addr_o        <= '0;
    end else if (!clear_i && state == S_DECODE) begin
      load_is_mat_o <= dec_mat;
      dest_o        <= dec_dest;
      src1_o        <= dec_src1;
      src2_o        <= dec_src2;
      len_o         <= LEN_WIDTH'(dec_len);
      addr_o        <= ADDR_WIDTH'(dec_addr);
    end
  end

  // Handshake pulses are suppressed in a cycle where clear_i is asserted.
  assign fetch_en_o    = (state == S_FETCH) && !clear_i;
  assign unit_start_o  = (state == S_DISPATCH && !clear_i) ? unit_sel_q : 4'b0000;
  assign busy_o        = !(state inside {S_IDLE, S_HALTED, S_ERROR});
  assign halted_o      = (state == S_HALTED);
  assign err_o         = (state == S_ERROR);
  assign err_code_o    = err_code_q;
  assign instr_count_o = count_q;

endmodule

// File: tb/tb_instr_dispatch_ctrl.sv
// Self-checking bench for instr_dispatch_ctrl: an instruction-level reference model
// checked every cycle, directed scenarios with literal expectations, then random traffic.
module tb_instr_dispatch_ctrl;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic        clear_i = 1'b0;
  logic        fetch_done_i = 1'b0;
  logic [63:0] instr_i = 64'd0;
  logic [3:0]  unit_done_i = 4'd0;
  logic        fetch_en_o;
  logic [3:0]  unit_start_o;
  logic        load_is_mat_o;
  logic [4:0]  dest_o, src1_o, src2_o;
  logic [19:0] len_o;
  logic [23:0] addr_o;
  logic        busy_o, halted_o, err_o;
  logic [1:0]  err_code_o;
  logic [31:0] instr_count_o;

  instr_dispatch_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start_i       (start_i),
    .clear_i       (clear_i),
    .fetch_en_o    (fetch_en_o),
    .fetch_done_i  (fetch_done_i),
    .instr_i       (instr_i),
    .unit_start_o  (unit_start_o),
    .unit_done_i   (unit_done_i),
    .load_is_mat_o (load_is_mat_o),
    .dest_o        (dest_o),
    .src1_o        (src1_o),
    .src2_o        (src2_o),
    .len_o         (len_o),
    .addr_o        (addr_o),
    .busy_o        (busy_o),
    .halted_o      (halted_o),
    .err_o         (err_o),
    .err_code_o    (err_code_o),
    .instr_count_o (instr_count_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Environment controls: fetch_mode 0 answers fetches, 1 never answers.
  // unit_mode 0 random delay, 1 never, 2 fixed delay, 3 wrong unit then right one.
  int          fetch_mode = 0;
  int          unit_mode = 0;
  int          unit_delay = 0;
  bit          unit_noise = 1'b0;
  bit          stray_req = 1'b0;
  logic [63:0] prog_q[$];
  logic [3:0]  start_log[$];

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input bit s, input bit c);
    @(posedge clk);
    #1 start_i = s;
    clear_i = c;
  endtask

  task automatic doReset();
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic checkZeros(input string name);
    checkOutput({name, "_ctrl"}, 64'({fetch_en_o, unit_start_o, busy_o, halted_o, err_o,
                                      err_code_o, instr_count_o}), 64'd0);
    checkOutput({name, "_fields"}, 64'({load_is_mat_o, dest_o, src1_o, src2_o, len_o, addr_o}), 64'd0);
  endtask

  // Returns at the falling edge where the selected event is first seen.
  task automatic waitFor(input int which, input string name);
    int n;
    bit hit;
    n = 0;
    hit = 1'b0;
    while (!hit && n < 200) begin
      @(negedge clk);
      n++;
      case (which)
        0:       hit = fetch_en_o;
        1:       hit = |unit_start_o;
        2:       hit = halted_o;
        default: hit = err_o;
      endcase
    end
    checks++;
    if (!hit) begin
      failures++;
      $display("[TB] FAIL wait_%s actual=timeout required=event", name);
    end
  endtask

  function automatic logic [63:0] mkInstr(input int op, input int d, input int s1, input int s2,
                                          input int len, input int addr);
    return {5'(op), 5'(d), 5'(s1), 5'(s2), 20'(len), 24'(addr)};
  endfunction

  function automatic logic [63:0] randInstr();
    logic [63:0] v;
    int r;
    int op;
    v = {$urandom, $urandom};
    r = $urandom_range(0, 15);
    if (r < 2)       op = 0;
    else if (r < 9)  op = $urandom_range(1, 5);
    else if (r < 11) op = 31;
    else if (r < 12) op = $urandom_range(6, 30);
    else             op = $urandom_range(1, 5);
    v[63:59] = 5'(op);
    return v;
  endfunction

  function automatic logic [3:0] unitOf(input int op);
    case (op)
      1, 2:    return 4'b0001;
      3:       return 4'b0010;
      4:       return 4'b0100;
      5:       return 4'b1000;
      default: return 4'b0000;
    endcase
  endfunction

  // Fetch stage stand-in.
  initial begin : fetch_env
    int d;
    forever begin
      @(negedge clk);
      if (stray_req) begin
        @(posedge clk);
        #1 fetch_done_i = 1'b1;
        instr_i = mkInstr(4, 1, 1, 1, 1, 1);
        @(posedge clk);
        #1 fetch_done_i = 1'b0;
        stray_req = 1'b0;
      end else if (fetch_en_o && fetch_mode == 0) begin
        d = $urandom_range(0, 2);
        repeat (d + 1) @(posedge clk);
        #1 fetch_done_i = 1'b1;
        instr_i = (prog_q.size() > 0) ? prog_q.pop_front() : randInstr();
        @(posedge clk);
        #1 fetch_done_i = 1'b0;
      end
    end
  end

  // Execution unit stand-in.
  initial begin : unit_env
    logic [3:0] sel;
    int d;
    forever begin
      @(negedge clk);
      if (unit_start_o != 4'b0000) begin
        sel = unit_start_o;
        case (unit_mode)
          0, 2: begin
            d = (unit_mode == 0) ? $urandom_range(0, 9) : unit_delay;
            repeat (d + 1) @(posedge clk);
            #1 unit_done_i = sel | (unit_noise ? (4'($urandom) & ~sel) : 4'b0000);
            @(posedge clk);
            #1 unit_done_i = 4'b0000;
          end
          3: begin
            @(posedge clk);
            #1 unit_done_i = (sel == 4'b0001) ? 4'b0010 : 4'b0001;
            @(posedge clk);
            #1 unit_done_i = 4'b0000;
            @(posedge clk);
            #1 unit_done_i = sel;
            @(posedge clk);
            #1 unit_done_i = 4'b0000;
          end
          default: ;
        endcase
      end
    end
  end

  // Instruction-level reference model, compared against the DUT every cycle.
  typedef enum int {M_IDLE, M_REQ, M_WAITF, M_DEC, M_ISSUE, M_RUN, M_HALT, M_ERR} mphase_t;
  mphase_t     m_ph = M_IDLE;
  logic [63:0] m_instr = 64'd0;
  logic [31:0] m_count = 32'd0;
  logic [1:0]  m_err = 2'd0;
  logic        m_mat = 1'b0;
  logic [4:0]  m_dest = 5'd0, m_src1 = 5'd0, m_src2 = 5'd0;
  logic [19:0] m_len = 20'd0;
  logic [23:0] m_addr = 24'd0;
  logic [3:0]  m_unit = 4'd0;
  int          m_elapsed = 0;

  always @(negedge clk) begin : ref_model
    int         op;
    bit         exp_fetch;
    logic [3:0] exp_start;
    logic [4:0] exp_status;
    if (!rst_n) begin
      m_ph = M_IDLE; m_instr = '0; m_count = '0; m_err = '0; m_mat = 1'b0;
      m_dest = '0; m_src1 = '0; m_src2 = '0; m_len = '0; m_addr = '0;
      m_unit = '0; m_elapsed = 0;
    end
    exp_fetch  = (m_ph == M_REQ) && !clear_i;
    exp_start  = (m_ph == M_ISSUE && !clear_i) ? m_unit : 4'b0000;
    exp_status = {m_ph != M_IDLE && m_ph != M_HALT && m_ph != M_ERR, m_ph == M_HALT, m_ph == M_ERR, m_err};
    checkOutput("fetch_en", 64'(fetch_en_o), 64'(exp_fetch));
    checkOutput("unit_start", 64'(unit_start_o), 64'(exp_start));
    checkOutput("status", 64'({busy_o, halted_o, err_o, err_code_o}), 64'(exp_status));
    checkOutput("instr_count", 64'(instr_count_o), 64'(m_count));
    checkOutput("fields", 64'({load_is_mat_o, dest_o, src1_o, src2_o, len_o, addr_o}),
                64'({m_mat, m_dest, m_src1, m_src2, m_len, m_addr}));
    if (unit_start_o != 4'b0000) start_log.push_back(unit_start_o);
    if (rst_n) begin
      if (clear_i) begin
        m_ph  = M_IDLE;
        m_err = 2'd0;
      end else begin
        case (m_ph)
          M_IDLE:  if (start_i) m_ph = M_REQ;
          M_REQ:   m_ph = M_WAITF;
          M_WAITF: if (fetch_done_i) begin m_instr = instr_i; m_ph = M_DEC; end
          M_DEC: begin
            op     = int'(m_instr >> 59);
            m_dest = m_instr[58:54];
            m_src1 = m_instr[53:49];
            m_src2 = m_instr[48:44];
            m_len  = m_instr[43:24];
            m_addr = m_instr[23:0];
            m_mat  = (op == 2);
            m_unit = unitOf(op);
            if (op == 0 || op == 31) begin
              m_count = m_count + 32'd1;
              m_ph    = (op == 0) ? M_REQ : M_HALT;
            end else if (m_unit == 4'b0000) begin
              m_err = 2'd1;
              m_ph  = M_ERR;
            end else begin
              m_ph = M_ISSUE;
            end
          end
          M_ISSUE: begin m_elapsed = 0; m_ph = M_RUN; end
          M_RUN: begin
            m_elapsed++;
            if ((unit_done_i & m_unit) != 4'b0000) begin
              m_count = m_count + 32'd1;
              m_ph    = M_REQ;
            end else if (m_elapsed >= TO) begin
              m_err = 2'd2;
              m_ph  = M_ERR;
            end
          end
          M_HALT:  if (start_i) m_ph = M_REQ;
          default: ;
        endcase
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    @(negedge clk);
    checkZeros("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // LOAD_M dispatch and one-cycle retire-to-fetch latency.
    unit_mode = 2; unit_delay = 0;
    prog_q.push_back(mkInstr(2, 3, 0, 0, 64, 24'h000100));
    prog_q.push_back(mkInstr(31, 0, 0, 0, 0, 0));
    applyStimulus(1, 0); applyStimulus(0, 0);
    waitFor(1, "t1_start");
    checkOutput("t1_unit_start", 64'(unit_start_o), 64'h1);
    checkOutput("t1_is_mat", 64'(load_is_mat_o), 64'h1);
    checkOutput("t1_addr", 64'(addr_o), 64'h100);
    checkOutput("t1_len", 64'(len_o), 64'd64);
    @(negedge clk); @(negedge clk);
    checkOutput("t1_fetch_after_retire", 64'(fetch_en_o), 64'h1);
    checkOutput("t1_count", 64'(instr_count_o), 64'd1);
    waitFor(2, "t1_halt");

    // NOP, GEMV, RELU, HALT then resume.
    doReset();
    unit_mode = 0; unit_noise = 1'b0;
    start_log.delete();
    prog_q.push_back(mkInstr(0, 0, 0, 0, 0, 0));
    prog_q.push_back(mkInstr(4, 2, 1, 0, 16, 24'h000040));
    prog_q.push_back(mkInstr(5, 4, 2, 0, 16, 0));
    prog_q.push_back(mkInstr(31, 0, 0, 0, 0, 0));
    applyStimulus(1, 0); applyStimulus(0, 0);
    waitFor(2, "t2_halt");
    checkOutput("t2_num_starts", 64'(start_log.size()), 64'd2);
    checkOutput("t2_start0", 64'(start_log.size() > 0 ? start_log[0] : 4'hF), 64'h4);
    checkOutput("t2_start1", 64'(start_log.size() > 1 ? start_log[1] : 4'hF), 64'h8);
    checkOutput("t2_count", 64'(instr_count_o), 64'd4);
    checkOutput("t2_busy", 64'(busy_o), 64'd0);
    prog_q.push_back(mkInstr(31, 0, 0, 0, 0, 0));
    applyStimulus(1, 0); applyStimulus(0, 0);
    @(negedge clk);
    checkOutput("t2_resume_fetch", 64'(fetch_en_o), 64'h1);
    waitFor(2, "t2_halt_again");

    // Illegal opcode: sticky error, start ignored, clear recovers.
    doReset();
    start_log.delete();
    prog_q.push_back(mkInstr(9, 1, 2, 3, 4, 5));
    applyStimulus(1, 0); applyStimulus(0, 0);
    waitFor(3, "t3_err");
    checkOutput("t3_err_code", 64'(err_code_o), 64'd1);
    checkOutput("t3_no_unit_start", 64'(start_log.size()), 64'd0);
    applyStimulus(1, 0); applyStimulus(0, 0);
    @(negedge clk);
    checkOutput("t3_err_kept", 64'({err_o, fetch_en_o}), 64'b10);
    applyStimulus(0, 1); applyStimulus(0, 0);
    @(negedge clk);
    checkOutput("t3_cleared", 64'({err_o, err_code_o, busy_o}), 64'd0);

    // Timeout after TO execution cycles; a done on the last one wins.
    doReset();
    unit_mode = 1;
    prog_q.push_back(mkInstr(3, 1, 0, 0, 8, 24'h0000F0));
    applyStimulus(1, 0); applyStimulus(0, 0);
    waitFor(1, "t4_start");
    checkOutput("t4_unit_start", 64'(unit_start_o), 64'h2);
    repeat (TO) @(negedge clk);
    checkOutput("t4_no_err_yet", 64'(err_o), 64'd0);
    @(negedge clk);
    checkOutput("t4_timeout", 64'({err_o, err_code_o}), 64'b110);
    applyStimulus(0, 1); applyStimulus(0, 0);
    unit_mode = 2; unit_delay = TO - 1;
    prog_q.push_back(mkInstr(3, 1, 0, 0, 8, 24'h0000F0));
    prog_q.push_back(mkInstr(31, 0, 0, 0, 0, 0));
    applyStimulus(1, 0); applyStimulus(0, 0);
    waitFor(1, "t4b_start");
    repeat (TO + 1) @(negedge clk);
    checkOutput("t4b_last_cycle_done", 64'({err_o, fetch_en_o}), 64'b01);
    checkOutput("t4b_count", 64'(instr_count_o), 64'd1);
    waitFor(2, "t4b_halt");

    // Done from the wrong unit is ignored.
    doReset();
    unit_mode = 3;
    prog_q.push_back(mkInstr(4, 7, 6, 5, 32, 24'h000200));
    prog_q.push_back(mkInstr(31, 0, 0, 0, 0, 0));
    applyStimulus(1, 0); applyStimulus(0, 0);
    waitFor(1, "t5_start");
    checkOutput("t5_unit_start", 64'(unit_start_o), 64'h4);
    @(negedge clk); @(negedge clk);
    checkOutput("t5_still_exec", 64'({busy_o, fetch_en_o, instr_count_o}), 64'({1'b1, 1'b0, 32'd0}));
    @(negedge clk); @(negedge clk);
    checkOutput("t5_retired", 64'({fetch_en_o, instr_count_o}), 64'({1'b1, 32'd1}));
    waitFor(2, "t5_halt");

    // Async reset in WAIT_F and in EXEC, then a stray fetch_done.
    doReset();
    fetch_mode = 1;
    applyStimulus(1, 0); applyStimulus(0, 0);
    waitFor(0, "t6_fetch");
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1 checkZeros("t6_reset_waitf");
    @(posedge clk);
    #1 rst_n = 1'b1;
    stray_req = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("t6_stray_ignored", 64'({busy_o, fetch_en_o}), 64'd0);
    fetch_mode = 0; unit_mode = 1;
    prog_q.push_back(mkInstr(0, 0, 0, 0, 0, 0));
    prog_q.push_back(mkInstr(3, 9, 8, 7, 100, 24'h123456));
    applyStimulus(1, 0); applyStimulus(0, 0);
    waitFor(1, "t6_start");
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1 checkZeros("t6_reset_exec");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Random traffic against the model.
    unit_mode = 0; unit_noise = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 799) == 0) doReset();
      applyStimulus($urandom_range(0, 5) == 0,
                    err_o ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 79) == 0));
    end
    applyStimulus(0, 0);
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
